shift_add_multiplier: RTL



---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/shift_add_multiplier_add_w_carry.sv | 27 ++
 rtl/shift_add_multiplier.sv | 117 +++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and default sizes for the shift-and-add multiplier.
// Holds the FSM state encoding and the default operand/accumulator widths.
// No logic; imported by the multiplier top and its adder.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_PROD_W = 2 * DEF_WIDTH;

endpackage

// File: rtl/shift_add_multiplier_add_w_carry.sv
// Combinational W-bit ripple-carry adder with carry-in tied low and a carry-out.
// Latency: purely combinational.
// Backpressure: none; it is a leaf arithmetic cell.
module add_w_carry
  import shift_add_multiplier_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one multiplier bit per clock.
// Latency: product valid WIDTH+1 cycles after the accept cycle; II = WIDTH+2.
// Backpressure: holds the product in DONE until out_ready; in_ready low while busy.
// Optional running accumulator of products is enabled by defining MUL_ACCUM_EN.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef MUL_ACCUM_EN
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     acc,
`endif
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [PW-1:0]    prod_nxt;
  logic             last_step;

  // Upper half of the product register plus the multiplicand when the current multiplier bit is set
  assign addend = prod[0] ? mcand : '0;

  add_w_carry #(.W(WIDTH)) u_add (
    .x    (prod[PW-1:WIDTH]),
    .y    (addend),
    .sum  (sum),
    .cout (carry_out)
  );

  // Adder result re-enters the top half while the consumed multiplier bit shifts out
  assign prod_nxt  = {carry_out, sum, prod[WIDTH-1:1]};
  assign last_step = (state == CALC) && (cnt == LAST_STEP);
  assign p         = prod;

  // Control FSM with registered handshake outputs; the datapath shifts only in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            prod     <= {{WIDTH{1'b0}}, b};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means the next accept is at least one cycle later
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef MUL_ACCUM_EN
  // Running sum updated as each product completes; clear wins over a same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (last_step) begin
      acc <= acc + ACC_W'(prod_nxt);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = last_step;
`endif

endmodule
